// File: rtl/gemm_pkg.sv
// Shared definitions for the fixed-point GEMM engine: write targets, FSM states,
// default geometry and the saturation helper used by the scaling datapath.
package gemm_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;
  localparam int DEF_M          = 4;
  localparam int DEF_N          = 4;
  localparam int DEF_K          = 4;

  // Working width of the saturation helper; callers sign-extend into it.
  localparam int SAT_W = 64;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_SCALE,
    S_OUT,
    S_DONE
  } state_t;

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] x,
    input int                      width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/gemm_if.sv
// Operand write port, job control and result stream of the GEMM engine,
// with the host/sink side as master and the engine as slave.
interface gemm_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 2
);

  logic                         wr_en;
  logic [1:0]                   wr_sel;
  logic [IDX_W-1:0]             wr_row;
  logic [IDX_W-1:0]             wr_col;
  logic signed [DATA_WIDTH-1:0] wr_data;

  logic                         start;
  logic signed [DATA_WIDTH-1:0] alpha;
  logic signed [DATA_WIDTH-1:0] beta;
  logic                         trans_b;
  logic                         busy;
  logic                         done;

  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]             out_row;
  logic [IDX_W-1:0]             out_col;
  logic                         out_last;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data,
    output start, alpha, beta, trans_b, out_ready,
    input  busy, done, out_valid, out_data, out_row, out_col, out_last
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data,
    input  start, alpha, beta, trans_b, out_ready,
    output busy, done, out_valid, out_data, out_row, out_col, out_last
  );

endinterface

// File: rtl/gemm_mac_unit.sv
// Dot-product accumulator plus the alpha/beta scaling, Q-format shift and
// saturation that produce one result element from the finished accumulation.
module gemm_mac_unit
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int ACC_WIDTH  = 2 * DEF_DATA_WIDTH + 3
) (
  input  logic                         clk_i,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [DATA_WIDTH-1:0] alpha_i,
  input  logic signed [DATA_WIDTH-1:0] beta_i,
  input  logic signed [DATA_WIDTH-1:0] c_i,
  output logic signed [DATA_WIDTH-1:0] res_o
);

  localparam int SUM_W = DATA_WIDTH + ACC_WIDTH + 1;

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] dot;
  logic signed [SUM_W-1:0]     sum;

  assign prod = ACC_WIDTH'(a_i) * ACC_WIDTH'(b_i);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + prod;
    end
  end

  // Scale stage: floor the Q2F dot product back to QF, then mix in beta*C at full width.
  assign dot   = acc_q >>> FRAC_BITS;
  assign sum   = SUM_W'(alpha_i) * SUM_W'(dot) + SUM_W'(beta_i) * SUM_W'(c_i);
  assign res_o = DATA_WIDTH'(saturate(SAT_W'(sum >>> FRAC_BITS), DATA_WIDTH));

endmodule

// File: rtl/gemm_engine.sv
// Fixed-point GEMM engine: R = alpha*(A x op(B)) + beta*C over internal operand
// storage, one element per K+2 cycles, streamed out in row-major order.
module gemm_engine
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int M          = DEF_M,
  parameter int N          = DEF_N,
  parameter int K          = DEF_K,
  parameter int IDX_W      = (((M >= N) && (M >= K)) ? M : ((N >= K) ? N : K)) > 1 ?
                             $clog2(((M >= N) && (M >= K)) ? M : ((N >= K) ? N : K)) : 1,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(K) + 1
) (
  input  logic iclk,
  input  logic irst_n,
  gemm_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int BDIM  = (K > N) ? K : N;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(K - 1);
  localparam logic [IDX_W-1:0] N_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] M_LAST = IDX_W'(M - 1);

  typedef logic signed [DATA_WIDTH-1:0] word_t;

  word_t a_q [DEPTH][DEPTH];
  word_t b_q [DEPTH][DEPTH];
  word_t c_q [DEPTH][DEPTH];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  word_t            alpha_q, alpha_d, beta_q, beta_d;
  logic             trans_q, trans_d;
  logic             valid_q, valid_d, last_q, last_d;
  word_t            data_q, data_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;

  logic  wr_ok;
  logic  acc_clr, acc_en;
  word_t a_op, b_op, c_op, mac_res;

  // Writes land only while idle so a running job always sees a frozen operand set.
  always_comb begin
    wr_ok = 1'b0;
    if (state_q == S_IDLE && bus.wr_en) begin
      unique case (bus.wr_sel)
        SEL_A:   wr_ok = (int'(bus.wr_row) < M)    && (int'(bus.wr_col) < K);
        SEL_B:   wr_ok = (int'(bus.wr_row) < BDIM) && (int'(bus.wr_col) < BDIM);
        SEL_C:   wr_ok = (int'(bus.wr_row) < M)    && (int'(bus.wr_col) < N);
        default: wr_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int c = 0; c < DEPTH; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
          c_q[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      unique case (bus.wr_sel)
        SEL_A:   a_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
        SEL_B:   b_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
        SEL_C:   c_q[bus.wr_row][bus.wr_col] <= bus.wr_data;
        default: ;
      endcase
    end
  end

  assign a_op = a_q[i_q][k_q];
  assign b_op = trans_q ? b_q[j_q][k_q] : b_q[k_q][j_q];
  assign c_op = c_q[i_q][j_q];

  gemm_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk_i   (iclk),
    .clr_i   (acc_clr),
    .en_i    (acc_en),
    .a_i     (a_op),
    .b_i     (b_op),
    .alpha_i (alpha_q),
    .beta_i  (beta_q),
    .c_i     (c_op),
    .res_o   (mac_res)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    trans_d = trans_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          alpha_d = bus.alpha;
          beta_d  = bus.beta;
          trans_d = bus.trans_b;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_en = 1'b1;
        if (k_q == K_LAST) state_d = S_SCALE;
        else               k_d     = k_q + 1'b1;
      end
      S_SCALE: begin
        data_d  = mac_res;
        row_d   = i_q;
        col_d   = j_q;
        last_d  = (i_q == M_LAST) && (j_q == N_LAST);
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          k_d     = '0;
          acc_clr = 1'b1;
          if (j_q == N_LAST) begin
            j_d = '0;
            i_d = (i_q == M_LAST) ? '0 : i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
          state_d = last_q ? S_DONE : S_MAC;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Job parameters only matter once latched by a start, so they carry no reset.
  always_ff @(posedge iclk) begin
    alpha_q <= alpha_d;
    beta_q  <= beta_d;
    trans_q <= trans_d;
  end

  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_gemm_engine.sv
// Scoreboard bench for gemm_engine: stimulus pushes expected elements, a
// monitor pops and compares every accepted result element.
`timescale 1ns/1ps
module tb_gemm_engine;
  import gemm_pkg::*;

  localparam int DW = 16;
  localparam int IW = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    logic          l;
  } elem_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   fails  = 0;

  elem_t         sb [$];
  elem_t         mon_got;
  elem_t         mon_want;
  logic [DW-1:0] exp_m [4][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gemm_if #(.DATA_WIDTH(DW), .IDX_W(IW)) bus ();

  gemm_engine #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (8),
    .M          (4),
    .N          (4),
    .K          (4),
    .IDX_W      (IW)
  ) dut (
    .iclk   (clk),
    .irst_n (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: every accepted element must be the next one the stimulus queued.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      mon_got = {bus.out_data, bus.out_row, bus.out_col, bus.out_last};
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL extra_element got=%h want=none (t=%0t)", mon_got, $time);
      end else begin
        mon_want = sb.pop_front();
        chk("out_element", 64'(mon_got), 64'(mon_want));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input int r, input int c, input logic [DW-1:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = IW'(r);
    bus.wr_col  = IW'(c);
    bus.wr_data = v;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic fill(input logic [1:0] sel, input logic [DW-1:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        wr(sel, r, c, v);
  endtask

  task automatic load_identity();
    fill(SEL_A, 16'h0000);
    for (int d = 0; d < 4; d++) wr(SEL_A, d, d, 16'h0100);
    fill(SEL_B, 16'h0200);
    fill(SEL_C, 16'h0100);
  endtask

  task automatic push_mat();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sb.push_back({exp_m[r][c], IW'(r), IW'(c), (r == 3 && c == 3)});
  endtask

  task automatic push_const(input logic [DW-1:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_m[r][c] = v;
    push_mat();
  endtask

  // Returns the cycle count right after the edge that sampled start.
  task automatic start_job(input logic [DW-1:0] al, input logic [DW-1:0] be,
                           input logic tr, output int s);
    bus.alpha   = al;
    bus.beta    = be;
    bus.trans_b = tr;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input string name, output int dc);
    int n;
    n  = 0;
    dc = -1;
    while (n < 400) begin
      @(negedge clk);
      if (bus.done) begin
        dc = cyc;
        chk({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        break;
      end
      n++;
    end
    if (dc < 0) begin
      checks++;
      fails++;
      $display("FAIL %s_done_timeout got=no_done want=done (t=%0t)", name, $time);
    end
    chk({name, "_all_elements"}, 64'(sb.size()), 64'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int dc;
    int n;
    bit found;

    bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.alpha = '0; bus.beta = '0; bus.trans_b = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({bus.busy, bus.done, bus.out_valid, bus.out_last,
                              bus.out_data, bus.out_row, bus.out_col}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Identity product: every element 2*1 + 1 = 3.0
    load_identity();
    push_const(16'h0300);
    start_job(16'h0100, 16'h0100, 1'b0, s);
    @(negedge clk);
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    wait_done("identity", dc);
    // done is high in the cycle closed by the 97th edge after the start edge
    chk("identity_done_cycle", 64'(dc - s), 64'd96);

    // Saturation in both directions
    fill(SEL_A, 16'h4000);
    fill(SEL_B, 16'h4000);
    fill(SEL_C, 16'h0000);
    push_const(16'h7FFF);
    start_job(16'h0100, 16'h0000, 1'b0, s);
    wait_done("sat_pos", dc);
    fill(SEL_A, 16'hC000);
    push_const(16'h8000);
    start_job(16'h0100, 16'h0000, 1'b0, s);
    wait_done("sat_neg", dc);

    // Transpose select
    fill(SEL_A, 16'h0000);
    for (int d = 0; d < 4; d++) wr(SEL_A, d, d, 16'h0100);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        wr(SEL_B, r, c, DW'(16'h0100 * (4 * r + c + 1)));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_m[r][c] = DW'(16'h0100 * (4 * r + c + 1));
    push_mat();
    start_job(16'h0100, 16'h0000, 1'b0, s);
    wait_done("no_transpose", dc);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_m[r][c] = DW'(16'h0100 * (4 * c + r + 1));
    push_mat();
    start_job(16'h0100, 16'h0000, 1'b1, s);
    wait_done("transpose", dc);

    // Backpressure on the first element
    load_identity();
    bus.out_ready = 1'b0;
    push_const(16'h0300);
    start_job(16'h0100, 16'h0100, 1'b0, s);
    found = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("first_valid_found", 64'(found), 64'd1);
    chk("first_valid_latency", 64'(cyc - s), 64'd5);
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      chk("bp_hold", 64'({bus.out_valid, bus.out_data, bus.out_row, bus.out_col}),
          64'({1'b1, 16'h0300, 3'd0, 3'd0}));
    end
    tick();
    bus.out_ready = 1'b1;
    wait_done("backpressure", dc);

    // Guards: start and A writes while busy are dropped; reserved target and out-of-range rows too
    push_const(16'h0300);
    start_job(16'h0100, 16'h0100, 1'b0, s);
    tick();
    wr(SEL_A, 0, 0, 16'h7000);
    bus.alpha = 16'h0200;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("busy_guard", dc);
    chk("busy_guard_done_cycle", 64'(dc - s), 64'd96);
    wr(2'd3, 0, 0, 16'h7000);
    wr(SEL_C, 5, 0, 16'h7000);
    wr(SEL_A, 0, 5, 16'h7000);
    push_const(16'h0300);
    start_job(16'h0100, 16'h0100, 1'b0, s);
    wait_done("write_guard", dc);

    // Reset during the MAC phase of element (1,2)
    push_const(16'h0300);
    start_job(16'h0100, 16'h0100, 1'b0, s);
    found = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_row == 3'd1 && bus.out_col == 3'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_elem_1_1", 64'(found), 64'd1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 64'({bus.busy, bus.out_valid, bus.done}), 64'd0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Storage must have been cleared by the reset
    push_const(16'h0000);
    start_job(16'h0100, 16'h0100, 1'b0, s);
    wait_done("cleared_storage", dc);

    load_identity();
    push_const(16'h0300);
    start_job(16'h0100, 16'h0100, 1'b0, s);
    wait_done("after_reset", dc);
    chk("after_reset_done_cycle", 64'(dc - s), 64'd96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
